// File: rtl/hms_set_timer.sv
// HH:MM:SS clock with button-driven set mode; time kept as packed BCD and
// advanced by a one-second prescaler, selected field blinks while being set.
module hms_set_timer #(
  parameter int TICK_DIV  = 100000000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [31:0] hms_hex,
  output logic [7:0]  aen,
  output logic [7:0]  dp_en,
  output logic [1:0]  mode
);

  typedef enum logic [1:0] {RUN = 2'd0, SET_HH = 2'd1, SET_MM = 2'd2, SET_SS = 2'd3} state_e;

  localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [7:0] AEN_ALL = 8'b00111111;

  state_e         state_q, state_d;
  logic           mode_prev_q, inc_prev_q;
  logic [TW-1:0]  pre_q, pre_d;
  logic [BW-1:0]  blink_q, blink_d;
  logic           phase_q, phase_d;
  logic [7:0]     hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic [7:0]     aen_q, aen_d;
  logic           mode_edge, inc_edge, tick;

  function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] maxv);
    if (v == maxv) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    mode_edge = btn_mode & ~mode_prev_q;
    inc_edge  = btn_inc  & ~inc_prev_q;
    state_d   = state_q;
    pre_d     = pre_q;
    blink_d   = blink_q;
    phase_d   = phase_q;
    hh_d      = hh_q;
    mm_d      = mm_q;
    ss_d      = ss_q;
    aen_d     = AEN_ALL;
    tick      = (state_q == RUN) && (pre_q == TW'(TICK_DIV - 1));

    if (mode_edge) state_d = state_e'(state_q + 2'd1);

    // Prescaler only free-runs while staying in RUN; any transition restarts it.
    if (state_q == RUN && state_d == RUN) pre_d = tick ? '0 : pre_q + 1'b1;
    else                                  pre_d = '0;

    if (tick) begin
      ss_d = bcd_next(ss_q, 8'h59);
      if (ss_q == 8'h59) begin
        mm_d = bcd_next(mm_q, 8'h59);
        if (mm_q == 8'h59) hh_d = bcd_next(hh_q, 8'h23);
      end
    end else if (inc_edge && !mode_edge) begin
      case (state_q)
        SET_HH:  hh_d = bcd_next(hh_q, 8'h23);
        SET_MM:  mm_d = bcd_next(mm_q, 8'h59);
        SET_SS:  ss_d = bcd_next(ss_q, 8'h59);
        default: ;
      endcase
    end

    if (state_d != state_q || state_d == RUN) begin
      blink_d = '0;
      phase_d = 1'b1;
    end else if (blink_q == BW'(BLINK_DIV - 1)) begin
      blink_d = '0;
      phase_d = ~phase_q;
    end else begin
      blink_d = blink_q + 1'b1;
    end

    // Enables are computed from next-state values so the flop lines up with mode.
    if (state_d != RUN && !phase_d) begin
      case (state_d)
        SET_HH:  aen_d = 8'b00001111;
        SET_MM:  aen_d = 8'b00110011;
        SET_SS:  aen_d = 8'b00111100;
        default: aen_d = AEN_ALL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      mode_prev_q <= 1'b0;
      inc_prev_q  <= 1'b0;
      pre_q       <= '0;
      blink_q     <= '0;
      phase_q     <= 1'b1;
      hh_q        <= 8'h00;
      mm_q        <= 8'h00;
      ss_q        <= 8'h00;
      aen_q       <= AEN_ALL;
    end else begin
      state_q     <= state_d;
      mode_prev_q <= btn_mode;
      inc_prev_q  <= btn_inc;
      pre_q       <= pre_d;
      blink_q     <= blink_d;
      phase_q     <= phase_d;
      hh_q        <= hh_d;
      mm_q        <= mm_d;
      ss_q        <= ss_d;
      aen_q       <= aen_d;
    end
  end

  assign hms_hex = {8'h00, hh_q, mm_q, ss_q};
  assign aen     = aen_q;
  assign dp_en   = 8'b00010100;
  assign mode    = state_q;

endmodule

// File: tb/tb_hms_set_timer.sv
// Directed + random bench for hms_set_timer; reference keeps time as seconds-of-day.
module tb_hms_set_timer;
  localparam int TICK  = 4;
  localparam int BLINK = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_mode = 1'b0;
  logic        btn_inc = 1'b0;
  logic [31:0] hms_hex;
  logic [7:0]  aen, dp_en;
  logic [1:0]  mode;

  int n_assert = 0;
  int n_fail   = 0;

  // reference state
  int secs, mmode, run_c, set_c;
  bit pm, pi;

  hms_set_timer #(.TICK_DIV(TICK), .BLINK_DIV(BLINK)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hms_hex(hms_hex), .aen(aen), .dp_en(dp_en), .mode(mode)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bcd2(input int n);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  function automatic logic [31:0] exp_hex();
    return {8'h00, bcd2(secs / 3600), bcd2((secs / 60) % 60), bcd2(secs % 60)};
  endfunction

  function automatic logic [7:0] exp_aen();
    if (mmode == 0 || ((set_c / BLINK) % 2) == 0) return 8'b00111111;
    case (mmode)
      1:       return 8'b00001111;
      2:       return 8'b00110011;
      default: return 8'b00111100;
    endcase
  endfunction

  task automatic model_reset();
    secs = 0; mmode = 0; run_c = 0; set_c = 0; pm = 0; pi = 0;
  endtask

  task automatic model_step(input bit m, input bit i);
    bit me, ie;
    int nm, h, mi, s;
    me = m && !pm;
    ie = i && !pi;
    pm = m;
    pi = i;
    nm = me ? (mmode + 1) % 4 : mmode;
    if (mmode == 0) begin
      run_c++;
      if (run_c % TICK == 0) secs = (secs + 1) % 86400;
    end else if (ie && !me) begin
      h = secs / 3600; mi = (secs / 60) % 60; s = secs % 60;
      case (mmode)
        1:       h  = (h + 1) % 24;
        2:       mi = (mi + 1) % 60;
        default: s  = (s + 1) % 60;
      endcase
      secs = h * 3600 + mi * 60 + s;
    end
    if (nm != mmode) begin run_c = 0; set_c = 0; end
    else set_c++;
    mmode = nm;
  endtask

  task automatic check_all();
    chk("hms_hex", hms_hex, exp_hex());
    chk("aen", {24'h0, aen}, {24'h0, exp_aen()});
    chk("mode", {30'h0, mode}, 32'(mmode));
    chk("dp_en", {24'h0, dp_en}, 32'h14);
  endtask

  task automatic cycle(input bit m, input bit i);
    btn_mode = m;
    btn_inc  = i;
    model_step(m, i);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic press_mode();
    cycle(1, 0);
    cycle(0, 0);
  endtask

  task automatic press_inc(input int n);
    for (int k = 0; k < n; k++) begin
      cycle(0, 1);
      cycle(0, 0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hex"}, hms_hex, 32'h0);
    chk({tag, "_mode"}, {30'h0, mode}, 32'h0);
    chk({tag, "_aen"}, {24'h0, aen}, 32'h3f);
    chk({tag, "_dp"}, {24'h0, dp_en}, 32'h14);
  endtask

  initial begin
    logic [7:0] blink_exp [6];
    blink_exp = '{8'h3f, 8'h33, 8'h33, 8'h3f, 8'h3f, 8'h33};
    model_reset();

    // power-on reset
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    #2 rst_n = 1'b1;

    // free-run: one minute at 4 cycles per second
    for (int k = 0; k < 240; k++) cycle(0, 0);
    chk("run240", hms_hex, 32'h00000100);

    // SET_HH: 25 increments wrap 00 -> 01, nothing else moves
    press_mode();
    chk("set_hh_mode", {30'h0, mode}, 32'd1);
    press_inc(25);
    chk("set_hh25", hms_hex, 32'h00010100);
    chk("set_hh_mode2", {30'h0, mode}, 32'd1);

    // preset toward 23:59:59; check SET_MM blinking and held inc
    press_inc(22);
    cycle(1, 0);
    chk("enter_mm_aen", {24'h0, aen}, 32'h3f);
    for (int k = 0; k < 6; k++) begin
      cycle(0, 0);
      chk("blink_mm", {24'h0, aen}, {24'h0, blink_exp[k]});
    end
    for (int k = 0; k < 5; k++) cycle(0, 1);
    cycle(0, 0);
    chk("held_inc", hms_hex, 32'h00230200);
    press_inc(57);
    press_mode();
    press_inc(59);
    chk("preset", hms_hex, 32'h00235959);
    chk("preset_mode", {30'h0, mode}, 32'd3);

    // simultaneous mode+inc in SET_SS: mode wins, SS untouched
    cycle(1, 1);
    chk("both_mode", {30'h0, mode}, 32'd0);
    chk("both_ss", hms_hex, 32'h00235959);
    for (int k = 0; k < 3; k++) cycle(0, 0);
    chk("pre_wrap", hms_hex, 32'h00235959);
    cycle(0, 0);
    chk("day_wrap", hms_hex, 32'h00000000);

    // random button activity against the reference
    for (int k = 0; k < 400; k++)
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    cycle(0, 0);

    // asynchronous reset in the middle of SET_MM editing
    for (int k = 0; k < 8 && mmode != 2; k++) press_mode();
    chk("reach_mm", {30'h0, mode}, 32'd2);
    press_inc(3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset_vals("async_rst");
    @(posedge clk);
    #1;
    chk_reset_vals("rst_hold");
    #2 rst_n = 1'b1;
    for (int k = 0; k < 20; k++) cycle(0, 0);
    chk("post_rst", hms_hex, 32'h00000005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/hms_set_timer.md
HMS_SET_TIMER -- requirements
Module: hms_set_timer

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100000000, meaning clk cycles per one-second tick.
REQ-002 The block SHALL have parameter BLINK_DIV, default 25000000, meaning clk cycles per blink half-period in set mode.
REQ-003 The block SHALL have port clk  input  1  system clock; the block uses one clock only.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port btn_mode  input  1  synchronous, debounced level; each rising edge advances the mode.
REQ-006 The block SHALL have port btn_inc  input  1  synchronous, debounced level; each rising edge increments the selected field.
REQ-007 The block SHALL have port hms_hex  output  32  BCD time in the layout 8'h00,HH,MM,SS, intended for the seg7 x input.
REQ-008 The block SHALL have port aen  output  8  digit enables, intended for seg7 aen.
REQ-009 The block SHALL have port dp_en  output  8  decimal-point enables, intended for seg7 dp_en.
REQ-010 The block SHALL have port mode  output  2  current state: 0=RUN, 1=SET_HH, 2=SET_MM, 3=SET_SS.

Function
REQ-011 Edge detection SHALL register each button and act only on a 0->1 transition; a held button acts once.
REQ-012 The state machine SHALL advance RUN->SET_HH->SET_MM->SET_SS->RUN, one step per btn_mode edge, in the cycle after the edge is detected.
REQ-013 In RUN, a prescaler SHALL count 0..TICK_DIV-1 and wrap; a tick occurs on the wrap cycle, and the time SHALL advance by 1 s in that cycle's register update.
REQ-014 Each BCD digit SHALL stay in 0-9; SS and MM tens digits SHALL stay in 0-5; HH SHALL stay in 00-23; hms_hex[31:24] SHALL always be 8'h00.
REQ-015 Carry rules: SS 59->00 increments MM; MM 59->00 increments HH; HH 23->00; 23:59:59 + tick -> 00:00:00 in one update.
REQ-016 In SET_xx states the prescaler SHALL hold at 0 and no tick occurs.
REQ-017 A btn_inc edge in a SET state SHALL increment only the selected field with wrap (HH 23->00, MM/SS 59->00) and no carry into other fields.
REQ-018 Entering SET_SS->RUN SHALL restart the prescaler at 0, so the first tick arrives TICK_DIV cycles after the transition.
REQ-019 btn_inc edges in RUN SHALL be ignored.
REQ-020 If a btn_mode edge and a btn_inc edge are detected in the same cycle, the mode change SHALL win and the increment SHALL be discarded.
REQ-021 A blink counter SHALL count 0..BLINK_DIV-1 in SET states, toggle a blink phase at each wrap, and hold at 0 with phase=on in RUN; the counter and phase SHALL reset to 0/on on every state change.
REQ-022 aen SHALL be 8'b00111111 in RUN and during the blink-on phase; during blink-off it SHALL clear the two bits of the selected field (HH=bits5:4, MM=3:2, SS=1:0).
REQ-023 dp_en SHALL be 8'b00010100 in all states.
REQ-024 All outputs SHALL be registered, with no combinational path from a button to any output.

Reset
REQ-025 While rst_n=0 the block SHALL hold hms_hex=32'h00000000, mode=0, aen=8'b00111111, dp_en=8'b00010100, with all counters and button history at 0.
REQ-026 Reset assertion in any state, including mid-set, SHALL apply immediately without waiting for clk, and SHALL discard any partially edited field.
REQ-027 After release the block SHALL be in RUN, and the first tick SHALL occur TICK_DIV cycles after the first active edge.

Verification (TICK_DIV=4, BLINK_DIV=2)
REQ-028 The bench SHALL cover: reset release then 240 cycles -> hms_hex=32'h00000100, with the tick every 4th cycle.
REQ-029 The bench SHALL cover: time preset via set mode to 23:59:59, return to RUN, then 4 cycles -> 32'h00000000 in one update.
REQ-030 The bench SHALL cover: mode edge, then 25 inc edges in SET_HH -> HH=01, MM/SS unchanged, no ticks, mode=1.
REQ-031 The bench SHALL cover: SET_MM with blinking -> aen alternates 8'b00111111/8'b00110011 every 2 cycles; a held btn_inc gives exactly one increment.
REQ-032 The bench SHALL cover: btn_mode and btn_inc rising edges in the same cycle in SET_SS -> mode=0 and SS unchanged.
REQ-033 The bench SHALL cover: rst_n pulsed low mid-cycle during SET_MM -> outputs are at reset values before the next clk edge, and mode=0.
